// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: blank pattern, segment
// bit positions and the active-low hex glyph table ({a,b,c,d,e,f,g,dp}).
package seg_pkg;

  // All segments dark (active-low outputs).
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Bit positions inside the 8-bit segment word.
  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  // Glyphs for 0..F, active-low, decimal point off. Index 0 is the leftmost entry.
  localparam logic [0:15][7:0] HEX_GLYPH = {
    8'h03, 8'h9F, 8'h25, 8'h0D,   // 0 1 2 3
    8'h99, 8'h49, 8'h41, 8'h1F,   // 4 5 6 7
    8'h01, 8'h09, 8'h11, 8'hC1,   // 8 9 A b
    8'h63, 8'h85, 8'h61, 8'h71    // C d E F
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational decoder: one hex nibble plus its decimal-point enable to an
// active-low segment word {a,b,c,d,e,f,g,dp}.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  // Look up the glyph, then overlay the decimal point (lit when dp=1).
  always_comb begin
    seg         = HEX_GLYPH[nibble];
    seg[SEG_DP] = ~dp;
  end

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed scanner for a common-anode N-digit seven-segment display.
// Data is loaded into a shadow buffer and copied to the active buffer only at
// a frame wrap, so a frame is never torn. Digit 0 is the leftmost digit.
// Optional macro SEG_BLINK_EN adds the blink_mask input and a blink phase
// that toggles every BLINK_FRAMES frame wraps.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 2000,
  parameter int IDX_W        = $clog2(DIGITS),
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  input  logic                  lz_en,
  input  logic                  blank,
`ifdef SEG_BLINK_EN
  input  logic [DIGITS-1:0]     blink_mask,
`endif
  output logic [IDX_W-1:0]      which,
  output logic [7:0]            seg,
  output logic                  pending,
  output logic                  frame_done
);

  localparam int                CNT_W    = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_data_q, shadow_data_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [4*DIGITS-1:0] act_data_q, act_data_d;
  logic [DIGITS-1:0]   act_dp_q, act_dp_d;
  logic                pending_q, pending_d;
  logic                frame_done_q, frame_done_d;
  logic [IDX_W-1:0]    which_q, which_d;
  logic [7:0]          seg_q, seg_d;

  logic                tick;
  logic                wrap;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                lead_zero;
  logic                suppress;
  logic                blink_dark;
  logic [7:0]          dec_seg;

  // Scan timing and double-buffer next state.
  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    tick          = (cnt_q == CNT_LAST);
    wrap          = tick && (idx_q == IDX_LAST);
    cnt_d         = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d         = idx_q;
    act_data_d    = act_data_q;
    act_dp_d      = act_dp_q;
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    pending_d     = pending_q;
    frame_done_d  = wrap;

    if (tick) begin
      // Explicit wrap: DIGITS need not be a power of two.
      idx_d = wrap ? '0 : idx_q + IDX_W'(1);
    end

    // Swap uses the shadow contents from before any coincident load.
    if (wrap) begin
      pending_d = 1'b0;
      if (pending_q) begin
        act_data_d = shadow_data_q;
        act_dp_d   = shadow_dp_q;
      end
    end

    // A load always wins over the clear at a wrap, so new data stays pending.
    if (load) begin
      shadow_data_d = data;
      shadow_dp_d   = dp;
      pending_d     = 1'b1;
    end
  end

  // Select the active digit and decide whether it is a suppressed leading zero.
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    lead_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib = act_data_q[4*(DIGITS-1-i) +: 4];
        cur_dp  = act_dp_q[DIGITS-1-i];
      end
      if ((IDX_W'(i) <= idx_q) && (act_data_q[4*(DIGITS-1-i) +: 4] != 4'h0)) begin
        lead_zero = 1'b0;
      end
    end
    // The rightmost digit always shows, so an all-zero value reads "0".
    suppress = lz_en && lead_zero && !cur_dp && (idx_q != IDX_LAST);
  end

  seg_hex_decode u_dec (
    .nibble (cur_nib),
    .dp     (cur_dp),
    .seg    (dec_seg)
  );

`ifdef SEG_BLINK_EN
  localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BF_W-1:0] blink_cnt_q, blink_cnt_d;
  logic            blink_off_q, blink_off_d;

  // Count frame wraps and flip the blink phase every BLINK_FRAMES of them.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_off_d = blink_off_q;
    if (wrap) begin
      if (blink_cnt_q == BF_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BF_W'(1);
      end
    end
    blink_dark = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        blink_dark = blink_off_q && blink_mask[DIGITS-1-i];
      end
    end
  end

  // Blink phase register; starts in the on phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
    end
  end
`else
  // Without the blink feature the phase is permanently on.
  assign blink_dark = 1'b0 && (BLINK_FRAMES > 0);
`endif

  // Registered output stage: which and seg always describe the same digit.
  always_comb begin
    which_d = idx_q;
    seg_d   = (blank || suppress || blink_dark) ? SEG_BLANK : dec_seg;
  end

  // State registers with synchronous reset; buffers are cleared too, so a
  // reset mid-frame also discards any pending load.
  // NOTE: non-blocking assignments here so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      act_data_q    <= '0;
      act_dp_q      <= '0;
      pending_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      which_q       <= '0;
      seg_q         <= SEG_BLANK;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      act_data_q    <= act_data_d;
      act_dp_q      <= act_dp_d;
      pending_q     <= pending_d;
      frame_done_q  <= frame_done_d;
      which_q       <= which_d;
      seg_q         <= seg_d;
    end
  end

  assign which      = which_q;
  assign seg        = seg_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed testbench for seg_scan_display with DIGITS=8, SCAN_DIV=4.
// Inputs are driven and outputs sampled on the falling clock edge.
// Build with SEG_BLINK_EN defined to also exercise the blink feature.
module tb_seg_scan_display;

  localparam int DIGITS   = 8;
  localparam int SCAN_DIV = 4;
  localparam int IDX_W    = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic [4*DIGITS-1:0] data;
  logic [DIGITS-1:0]   dp;
  logic                load;
  logic                lz_en;
  logic                blank;
`ifdef SEG_BLINK_EN
  logic [DIGITS-1:0]   blink_mask;
`endif
  logic [IDX_W-1:0]    which;
  logic [7:0]          seg;
  logic                pending;
  logic                frame_done;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  seg_scan_display #(
    .DIGITS       (DIGITS),
    .SCAN_DIV     (SCAN_DIV),
    .BLINK_FRAMES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .dp         (dp),
    .load       (load),
    .lz_en      (lz_en),
    .blank      (blank),
`ifdef SEG_BLINK_EN
    .blink_mask (blink_mask),
`endif
    .which      (which),
    .seg        (seg),
    .pending    (pending),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] p);
    data = d;
    dp   = p;
    load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  // Returns on the falling edge where frame_done is high (frame position j=0).
  task automatic wait_frame();
    bit got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      step(1);
      if (frame_done) got = 1'b1;
    end
    check("frame_done_arrives", 32'(got), 32'd1);
  endtask

  // From j=0, checks one whole frame; exp holds digit 0 in bits [63:56].
  task automatic check_frame(input string tag, input logic [63:0] exp);
    step(1);
    for (int d = 0; d < DIGITS; d++) begin
      for (int c = 0; c < SCAN_DIV; c++) begin
        check({tag, "_which"}, 32'(which), 32'(d));
        check({tag, "_seg"}, 32'(seg), 32'(exp[8*(7-d) +: 8]));
        step(1);
      end
    end
  endtask

  initial begin
    logic [7:0] blink_exp [6];
    rst   = 1'b1;
    load  = 1'b0;
    lz_en = 1'b0;
    blank = 1'b0;
    data  = '0;
    dp    = '0;
`ifdef SEG_BLINK_EN
    blink_mask = '0;
`endif
    blink_exp = '{8'h85, 8'hFF, 8'hFF, 8'h85, 8'h85, 8'hFF};

    // Reset state.
    step(2);
    check("rst_which", 32'(which), 32'd0);
    check("rst_seg", 32'(seg), 32'hFF);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;

    // Basic hex scan.
    do_load(32'h0123_ABCD, 8'h00);
    check("load_pending", 32'(pending), 32'd1);
    wait_frame();
    check("swap_pending_clear", 32'(pending), 32'd0);
    check_frame("hex", {8'h03, 8'h9F, 8'h25, 8'h0D, 8'h11, 8'hC1, 8'h63, 8'h85});

    // Back-to-back loads mid-frame: last wins, current frame untouched.
    wait_frame();
    step(13);
    check("b2b_digit3", 32'(which), 32'd3);
    data = 32'h1111_1111; load = 1'b1;
    step(1);
    load = 1'b0;
    step(1);
    data = 32'h2222_2222; load = 1'b1;
    step(1);
    load = 1'b0;
    check("b2b_pending", 32'(pending), 32'd1);
    step(1);
    check("b2b_same_which", 32'(which), 32'd4);
    check("b2b_same_seg", 32'(seg), 32'h11);
    wait_frame();
    check("b2b_pending_drop", 32'(pending), 32'd0);
    check_frame("b2b_all2", {8{8'h25}});

    // Leading-zero suppression.
    lz_en = 1'b1;
    do_load(32'h0000_0A05, 8'h00);
    wait_frame();
    check_frame("lz_0a05", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h11, 8'h03, 8'h49});
    do_load(32'h0000_0000, 8'h00);
    wait_frame();
    check_frame("lz_zero", {{7{8'hFF}}, 8'h03});
    lz_en = 1'b0;

    // Decimal point and blanking across a frame wrap.
    do_load(32'h0123_ABCD, 8'h80);
    wait_frame();
    step(1);
    check("dp_which0", 32'(which), 32'd0);
    check("dp_seg0", 32'(seg), 32'h02);
    step(4);
    check("dp_which1", 32'(which), 32'd1);
    check("dp_seg1", 32'(seg), 32'h9F);
    wait_frame();
    step(27);
    blank = 1'b1;
    for (int j = 28; j <= 37; j++) begin
      step(1);
      check("blank_seg", 32'(seg), 32'hFF);
      check("blank_which", 32'(which), 32'(((j - 1) / 4) % 8));
      check("blank_frame_done", 32'(frame_done), (j == 32) ? 32'd1 : 32'd0);
    end
    blank = 1'b0;
    step(1);
    check("unblank_which", 32'(which), 32'd1);
    check("unblank_seg", 32'(seg), 32'h9F);

    // Load exactly at the wrap, then reset mid-frame.
    wait_frame();
    do_load(32'h8765_4321, 8'h00);
    check("wrapload_pend_a", 32'(pending), 32'd1);
    step(30);
    data = 32'hFEDC_BA98; load = 1'b1;
    step(1);
    load = 1'b0;
    check("wrapload_frame_done", 32'(frame_done), 32'd1);
    check("wrapload_pending", 32'(pending), 32'd1);
    step(1);
    check("wrapload_which0", 32'(which), 32'd0);
    check("wrapload_old_seg0", 32'(seg), 32'h01);
    step(8);
    check("wrapload_which2", 32'(which), 32'd2);
    check("wrapload_old_seg2", 32'(seg), 32'h41);
    rst = 1'b1;
    step(1);
    check("midrst_which", 32'(which), 32'd0);
    check("midrst_seg", 32'(seg), 32'hFF);
    check("midrst_pending", 32'(pending), 32'd0);
    check("midrst_frame_done", 32'(frame_done), 32'd0);
    step(1);
    rst = 1'b0;
    wait_frame();
    check("postrst_pending", 32'(pending), 32'd0);
    check_frame("postrst_zero", {8{8'h03}});

`ifdef SEG_BLINK_EN
    // Blink: digit 7 lit for the frames after wraps 1 and 4..5, dark after 2..3 and 6.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    blink_mask = 8'h01;
    do_load(32'h0123_ABCD, 8'h00);
    for (int w = 0; w < 6; w++) begin
      wait_frame();
      step(25);
      check("blink_which6", 32'(which), 32'd6);
      check("blink_seg6", 32'(seg), 32'h63);
      step(4);
      check("blink_which7", 32'(which), 32'd7);
      check("blink_seg7", 32'(seg), 32'(blink_exp[w]));
    end
    blink_mask = '0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Parametrised time-multiplexed scanner for a common-anode N-digit seven-segment display.
- Successor to the fixed 8-digit hex scanner. Adds:
  - configurable digit count and scan rate
  - synchronous reset
  - double-buffered data load with tear-free frame-boundary update
  - per-digit decimal points
  - leading-zero suppression
  - global blanking and a frame-done strobe
- Sits between CPU/test datapath status registers and the board's digit-select and segment pins.

Parameters:
- DIGITS, 8, number of digits scanned (2..16).
- SCAN_DIV, 2000, clk cycles each digit is driven (>=2).
- IDX_W, $clog2(DIGITS), width of the digit-select index (derived; do not override).
- BLINK_FRAMES, 64, frames per blink half-period (used only with SEG_BLINK_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- data  in  4*DIGITS  hex nibbles; [4*DIGITS-1 -: 4] is digit 0 (leftmost, most significant)
- dp  in  DIGITS  decimal-point enables; dp[DIGITS-1] is digit 0
- load  in  1  single-cycle strobe; captures data/dp into the shadow buffer
- lz_en  in  1  leading-zero suppression enable (level)
- blank  in  1  forces every digit dark (level)
- which  out  IDX_W  digit-select index currently driven
- seg  out  8  segments {a,b,c,d,e,f,g,dp}, active-low; seg[7]=a, seg[0]=dp
- pending  out  1  shadow holds data not yet displayed
- frame_done  out  1  one-cycle pulse at each frame wrap

Behaviour:
- Reset values (rst=1 at a clk edge):
  - which=0, seg=8'hFF, pending=0, frame_done=0.
  - Scan counter, internal index, shadow buffer and active buffer all clear to 0.
  - Reset mid-frame aborts the frame; any pending load is discarded.
- Scan counter:
  - Counts 0..SCAN_DIV-1.
  - Terminal count produces a tick, so the digit period is exactly SCAN_DIV cycles.
- Internal index:
  - Advances on each tick.
  - Wraps from DIGITS-1 to 0; wrap is explicit, and DIGITS need not be a power of 2.
- Frame wrap (tick while index==DIGITS-1):
  - frame_done=1 for that cycle only.
  - If pending=1, the shadow buffer is copied to the active buffer and pending clears.
- Load:
  - load=1 writes data/dp into the shadow buffer and sets pending.
  - Back-to-back loads overwrite; the last one wins.
  - Load coincident with a frame swap: the swap uses the old shadow contents, the new data lands in the shadow, and pending stays 1.
- Output stage:
  - which and seg are registered together every cycle from the internal index and the active buffer.
  - They always describe the same digit, one cycle behind the index.
  - The active buffer never changes mid-frame, so no tearing.
- Nibble decode:
  - Standard hex glyph table: 0=8'b0000_0011, 8=8'b0000_0001, F=8'b0111_0001, etc.
  - The dp bit is seg[0]=~dp[i].
- Leading-zero suppression (lz_en=1):
  - Digit i is dark (8'hFF) when it and every digit left of it are 0 and its dp is clear.
  - Digit DIGITS-1 is never suppressed, so all-zero data shows a single "0".
  - Leading-zero status is computed from the active buffer only.
- blank=1 forces seg=8'hFF from the next cycle. Scanning, loading and frame_done continue unaffected.

Optional Feature:
- Macro: SEG_BLINK_EN.
- Defined:
  - Adds input blink_mask[DIGITS-1:0] (bit DIGITS-1-i maps to digit i).
  - A frame counter toggles a blink phase every BLINK_FRAMES frame wraps.
  - In the off phase, masked digits output 8'hFF.
  - Phase and counter reset to on/0.
- Undefined: the port, counter and phase logic are absent, and no digit ever blinks.

Decomposition:
- Package seg_pkg holds:
  - SEG_BLANK=8'hFF
  - segment bit-position constants
  - the 16-entry hex glyph constant table
- One natural sub-module, seg_hex_decode: combinational nibble+dp to 8-bit active-low segments. It is instantiated once on the selected digit.
- Scanning, buffering and suppression stay in the top block.

Test Plan:
- Use DIGITS=8 and SCAN_DIV=4 for all scenarios.
- Reset then load data=32'h0123_ABCD, dp=0: after the first frame wrap, one full frame shows which 0..7 each held 4 cycles, with seg 0000_0011, 1001_1111, 0010_0101, 0000_1101, 0001_0001, 1100_0001, 0110_0011, 1000_0101.
- Load 32'h1111_1111 during digit 3, then 32'h2222_2222 two cycles later: the current frame is unchanged, the next frame shows all "2" (0010_0101), and pending drops at the wrap.
- lz_en=1 with data=32'h0000_0A05 (leftmost significant digit 5): digits 0..4 give 8'hFF, then A, 0 (0000_0011), 5; data=0 gives only digit 7 = 0000_0011.
- dp=8'h80, blank pulse high for 10 cycles: digit 0 seg=0000_0010; during blank seg=8'hFF while which keeps advancing and frame_done still pulses every 32 cycles.
- Load asserted exactly at the frame-wrap cycle, then rst mid-frame: the old shadow is displayed, pending stays 1; after rst, which=0, seg=8'hFF, pending=0, and the display shows 0 after the next wrap.
- (SEG_BLINK_EN, BLINK_FRAMES=2) blink_mask=8'h01: digit 7 is dark for 2 frames then lit for 2 frames, alternating; all other digits are unaffected.
